// File: rtl/hazard_control_unit.sv
// Pipeline hazard controller: turns load-use, taken-branch and data-memory wait
// conditions into stall/flush/PC-redirect strobes and keeps saturating event counters.
module hazard_control_unit #(
    parameter int unsigned NUM_REGISTERS_LOG2 = 5,
    parameter int unsigned MEM_OP_BITS        = 2,
    parameter int unsigned LOAD_USE_STALLS    = 1,
    parameter int unsigned MEM_TIMEOUT        = 255,
    parameter int unsigned CNT_WIDTH          = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REGISTERS_LOG2-1:0] if_id_rs,
    input  logic [NUM_REGISTERS_LOG2-1:0] if_id_rt,
    input  logic [NUM_REGISTERS_LOG2-1:0] id_ex_rt,
    input  logic                          id_ex_mem_to_reg,
    input  logic                          ex_mem_beq,
    input  logic                          ex_mem_bne,
    input  logic                          ex_mem_compare,
    input  logic [MEM_OP_BITS-1:0]        ex_mem_mem_op,
    input  logic                          mem_ready,
    output logic                          stall_if,
    output logic                          stall_id,
    output logic                          flush_id_ex,
    output logic                          flush_ex_mem,
    output logic                          pc_load_branch,
    output logic                          mem_timeout_err,
    output logic [CNT_WIDTH-1:0]          stall_count,
    output logic [CNT_WIDTH-1:0]          flush_count,
    output logic [1:0]                    dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_LOAD_STALL = 2'd1,
        ST_MEM_WAIT   = 2'd2
    } state_t;

    localparam int unsigned    WAIT_W      = $clog2(MEM_TIMEOUT + 1);
    localparam logic [2:0]     BUBBLE_INIT = 3'(LOAD_USE_STALLS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [2:0]           bubble_q, bubble_d;
    logic [WAIT_W-1:0]    wait_q, wait_d;
    logic [WAIT_W-1:0]    wait_inc;
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic taken, load_use, mem_busy;
    logic stall, flush, stall_inc, flush_inc;

    assign taken    = (ex_mem_beq & ex_mem_compare) | (ex_mem_bne & ~ex_mem_compare);
    assign load_use = id_ex_mem_to_reg & (id_ex_rt != '0) &
                      ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));
    assign mem_busy = (ex_mem_mem_op != '0) & ~mem_ready;
    assign wait_inc = wait_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        bubble_d  = bubble_q;
        wait_d    = wait_q;
        err_d     = err_q;
        stall     = 1'b0;
        flush     = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (taken) begin
                    flush     = 1'b1;
                    flush_inc = 1'b1;
                end else if (mem_busy) begin
                    stall     = 1'b1;
                    stall_inc = 1'b1;
                    // A timeout of one cycle expires on the entry cycle itself.
                    if (MEM_TIMEOUT <= 1) begin
                        err_d  = 1'b1;
                        wait_d = '0;
                    end else begin
                        wait_d  = WAIT_W'(1);
                        state_d = ST_MEM_WAIT;
                    end
                end else if (load_use) begin
                    stall     = 1'b1;
                    stall_inc = 1'b1;
                    if (LOAD_USE_STALLS > 1) begin
                        bubble_d = BUBBLE_INIT;
                        state_d  = ST_LOAD_STALL;
                    end
                end
            end
            ST_LOAD_STALL: begin
                if (taken) begin
                    flush     = 1'b1;
                    flush_inc = 1'b1;
                    bubble_d  = '0;
                    state_d   = ST_RUN;
                end else begin
                    stall     = 1'b1;
                    stall_inc = 1'b1;
                    bubble_d  = bubble_q - 1'b1;
                    if (bubble_q <= 3'd1) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                // Branches are not evaluated here: a branch never carries a memory op.
                if (mem_busy) begin
                    stall     = 1'b1;
                    stall_inc = 1'b1;
                    if (wait_inc >= WAIT_LIMIT) begin
                        err_d   = 1'b1;
                        wait_d  = '0;
                        state_d = ST_RUN;
                    end else begin
                        wait_d = wait_inc;
                    end
                end else begin
                    wait_d  = '0;
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d  = ST_RUN;
                bubble_d = '0;
                wait_d   = '0;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (flush_inc && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            bubble_q    <= '0;
            wait_q      <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            bubble_q    <= bubble_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Strobes are forced low while reset is held, even if hazard inputs are active.
    assign stall_if        = reset_n & stall;
    assign stall_id        = reset_n & stall;
    assign flush_id_ex     = reset_n & flush;
    assign flush_ex_mem    = reset_n & flush;
    assign pc_load_branch  = reset_n & flush;
    assign mem_timeout_err = err_q;
    assign stall_count     = stall_cnt_q;
    assign flush_count     = flush_cnt_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Bench for hazard_control_unit: two instances (1 and 3 load-use bubbles) share stimulus;
// directed vector table, multi-cycle corner sequences, then random traffic vs a reference model.
module tb_hazard_control_unit;

    localparam int MT = 8;

    logic       clk;
    logic       reset_n;
    logic [4:0] rs, rt, ex_rt;
    logic       m2r, beq, bne, cmp;
    logic [1:0] op;
    logic       rdy;

    logic        s_if [2];
    logic        s_id [2];
    logic        f_ie [2];
    logic        f_em [2];
    logic        pcl  [2];
    logic        err  [2];
    logic [1:0]  dbg  [2];
    logic [15:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;

    int n_chk;
    int n_fail;

    hazard_control_unit #(.LOAD_USE_STALLS(1), .MEM_TIMEOUT(MT), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .reset_n(reset_n), .if_id_rs(rs), .if_id_rt(rt), .id_ex_rt(ex_rt),
        .id_ex_mem_to_reg(m2r), .ex_mem_beq(beq), .ex_mem_bne(bne), .ex_mem_compare(cmp),
        .ex_mem_mem_op(op), .mem_ready(rdy), .stall_if(s_if[0]), .stall_id(s_id[0]),
        .flush_id_ex(f_ie[0]), .flush_ex_mem(f_em[0]), .pc_load_branch(pcl[0]),
        .mem_timeout_err(err[0]), .stall_count(sc_a), .flush_count(fc_a), .dbg_state(dbg[0])
    );

    hazard_control_unit #(.LOAD_USE_STALLS(3), .MEM_TIMEOUT(MT), .CNT_WIDTH(4)) dut_b (
        .clk(clk), .reset_n(reset_n), .if_id_rs(rs), .if_id_rt(rt), .id_ex_rt(ex_rt),
        .id_ex_mem_to_reg(m2r), .ex_mem_beq(beq), .ex_mem_bne(bne), .ex_mem_compare(cmp),
        .ex_mem_mem_op(op), .mem_ready(rdy), .stall_if(s_if[1]), .stall_id(s_id[1]),
        .flush_id_ex(f_ie[1]), .flush_ex_mem(f_em[1]), .pc_load_branch(pcl[1]),
        .mem_timeout_err(err[1]), .stall_count(sc_b), .flush_count(fc_b), .dbg_state(dbg[1])
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: remaining bubbles, waiting flag and wait length, counts as plain ints
    int lus  [2] = '{1, 3};
    int cmax [2] = '{65535, 15};
    int m_bub [2];
    int m_wait[2];
    int m_wl  [2];
    int m_err [2];
    int m_sc  [2];
    int m_fc  [2];
    int e_stall[2];
    int e_flush[2];

    function automatic int inc_sat(int v, int mx);
        return (v < mx) ? v + 1 : v;
    endfunction

    function automatic bit f_taken();
        return (beq && cmp) || (bne && !cmp);
    endfunction

    function automatic bit f_busy();
        return (op != 0) && !rdy;
    endfunction

    function automatic bit f_lu();
        return m2r && (ex_rt != 0) && ((ex_rt == rs) || (ex_rt == rt));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_bub[i] = 0; m_wait[i] = 0; m_wl[i] = 0;
            m_err[i] = 0; m_sc[i] = 0; m_fc[i] = 0;
        end
    endtask

    task automatic model_expect(input int i);
        e_stall[i] = 0;
        e_flush[i] = 0;
        if (reset_n) begin
            if (m_wait[i] != 0) e_stall[i] = int'(f_busy());
            else if (m_bub[i] > 0) begin
                if (f_taken()) e_flush[i] = 1;
                else e_stall[i] = 1;
            end else if (f_taken()) e_flush[i] = 1;
            else if (f_busy() || f_lu()) e_stall[i] = 1;
        end
    endtask

    task automatic model_update(input int i);
        if (m_wait[i] != 0) begin
            if (f_busy()) begin
                m_sc[i] = inc_sat(m_sc[i], cmax[i]);
                m_wl[i]++;
                if (m_wl[i] >= MT) begin
                    m_err[i] = 1; m_wait[i] = 0; m_wl[i] = 0;
                end
            end else begin
                m_wait[i] = 0; m_wl[i] = 0;
            end
        end else if (m_bub[i] > 0) begin
            if (f_taken()) begin
                m_fc[i] = inc_sat(m_fc[i], cmax[i]);
                m_bub[i] = 0;
            end else begin
                m_sc[i] = inc_sat(m_sc[i], cmax[i]);
                m_bub[i]--;
            end
        end else if (f_taken()) begin
            m_fc[i] = inc_sat(m_fc[i], cmax[i]);
        end else if (f_busy()) begin
            m_sc[i] = inc_sat(m_sc[i], cmax[i]);
            m_wait[i] = 1; m_wl[i] = 1;
        end else if (f_lu()) begin
            m_sc[i] = inc_sat(m_sc[i], cmax[i]);
            m_bub[i] = lus[i] - 1;
        end
    endtask

    // scoreboard
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic compare(input int i);
        string p;
        logic [31:0] a_sc, a_fc;
        p    = (i == 0) ? "A" : "B";
        a_sc = (i == 0) ? 32'(sc_a) : 32'(sc_b);
        a_fc = (i == 0) ? 32'(fc_a) : 32'(fc_b);
        chk({p, ".stall_if"},       32'(s_if[i]), e_stall[i]);
        chk({p, ".stall_id"},       32'(s_id[i]), e_stall[i]);
        chk({p, ".flush_id_ex"},    32'(f_ie[i]), e_flush[i]);
        chk({p, ".flush_ex_mem"},   32'(f_em[i]), e_flush[i]);
        chk({p, ".pc_load_branch"}, 32'(pcl[i]),  e_flush[i]);
        chk({p, ".mem_timeout_err"}, 32'(err[i]), m_err[i]);
        chk({p, ".stall_count"},    a_sc, m_sc[i]);
        chk({p, ".flush_count"},    a_fc, m_fc[i]);
    endtask

    task automatic check_now();
        if (!reset_n) model_reset();
        for (int i = 0; i < 2; i++) begin
            model_expect(i);
            compare(i);
        end
    endtask

    // called #0 after inputs are driven on a negedge; posedge follows 4 units later
    task automatic step();
        #1;
        check_now();
        if (reset_n) begin
            for (int i = 0; i < 2; i++) model_update(i);
        end
    endtask

    // driver
    task automatic drive(input logic [4:0] a_rs, a_rt, a_ex_rt, input logic a_m2r, a_beq,
                         a_bne, a_cmp, input logic [1:0] a_op, input logic a_rdy);
        rs = a_rs; rt = a_rt; ex_rt = a_ex_rt; m2r = a_m2r;
        beq = a_beq; bne = a_bne; cmp = a_cmp; op = a_op; rdy = a_rdy;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    typedef struct {
        logic [4:0] rs, rt, ex_rt;
        logic       m2r, beq, bne, cmp;
        logic [1:0] op;
        logic       rdy;
        logic       e_stall, e_flush;
        int         e_sc, e_fc;
    } vec_t;

    function automatic vec_t mk(input logic [4:0] a_rs, a_rt, a_ex_rt, input logic a_m2r,
                                a_beq, a_bne, a_cmp, input logic [1:0] a_op, input logic a_rdy,
                                input logic a_st, a_fl, input int a_sc, a_fc);
        vec_t v;
        v.rs = a_rs; v.rt = a_rt; v.ex_rt = a_ex_rt; v.m2r = a_m2r;
        v.beq = a_beq; v.bne = a_bne; v.cmp = a_cmp; v.op = a_op; v.rdy = a_rdy;
        v.e_stall = a_st; v.e_flush = a_fl; v.e_sc = a_sc; v.e_fc = a_fc;
        return v;
    endfunction

    vec_t tbl[16];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        model_reset();

        // expected counts are those visible during the row, before its clock edge (instance A)
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        tbl[1]  = mk(3, 0, 3, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0);
        tbl[2]  = mk(3, 0, 3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        tbl[4]  = mk(3, 0, 3, 1, 0, 1, 0, 0, 1, 0, 1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 2, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 3, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 4, 1);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 5, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 1, 5, 1);
        tbl[13] = mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 5, 2);
        tbl[14] = mk(0, 7, 7, 1, 0, 0, 0, 0, 1, 1, 0, 5, 2);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 6, 2);

        // reset held with every hazard active: strobes must stay low
        reset_n = 1'b0;
        drive(3, 3, 3, 1, 1, 1, 1, 1, 0);
        @(negedge clk);
        #1;
        check_now();
        chk("A.reset_state", 32'(dbg[0]), 0);
        chk("B.reset_state", 32'(dbg[1]), 0);

        // directed vector table
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            reset_n = 1'b1;
            drive(tbl[k].rs, tbl[k].rt, tbl[k].ex_rt, tbl[k].m2r, tbl[k].beq, tbl[k].bne,
                  tbl[k].cmp, tbl[k].op, tbl[k].rdy);
            #1;
            chk($sformatf("tbl%0d.stall", k), 32'(s_if[0]), 32'(tbl[k].e_stall));
            chk($sformatf("tbl%0d.flush", k), 32'(f_ie[0] & f_em[0] & pcl[0]), 32'(tbl[k].e_flush));
            chk($sformatf("tbl%0d.stall_count", k), 32'(sc_a), tbl[k].e_sc);
            chk($sformatf("tbl%0d.flush_count", k), 32'(fc_a), tbl[k].e_fc);
            #0;
            check_now();
            for (int i = 0; i < 2; i++) model_update(i);
        end

        // memory timeout: error rises after the 8th wait cycle and stays set
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); step();
        end
        for (int k = 1; k <= MT + 1; k++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
            step();
            if (k == MT) chk("A.err_before_timeout", 32'(err[0]), 0);
            if (k == MT + 1) begin
                chk("A.err_after_timeout", 32'(err[0]), 1);
                chk("A.state_run_after_timeout", 32'(dbg[0]), 0);
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); idle(); step();
        end
        chk("A.err_sticky", 32'(err[0]), 1);
        chk("B.err_sticky", 32'(err[1]), 1);

        // reset asserted during the 2nd load-use bubble of instance B
        @(negedge clk);
        drive(3, 0, 3, 1, 0, 0, 0, 0, 1);
        step();
        @(negedge clk);
        step();
        chk("B.in_bubble", 32'(s_if[1]), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check_now();
        chk("B.stall_during_reset", 32'(s_if[1]), 0);
        chk("B.state_during_reset", 32'(dbg[1]), 0);
        chk("B.count_during_reset", 32'(sc_b), 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle();
        step();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); idle(); step();
            chk("B.no_stall_after_reset", 32'(s_if[1]), 0);
        end

        // random traffic; second half makes the memory slow enough to hit timeouts
        for (int k = 0; k < 800; k++) begin
            @(negedge clk);
            reset_n = ($urandom_range(0, 149) != 0);
            rs    = 5'($urandom_range(0, 3));
            rt    = 5'($urandom_range(0, 3));
            ex_rt = 5'($urandom_range(0, 3));
            m2r   = 1'($urandom_range(0, 1));
            beq   = ($urandom_range(0, 5) == 0);
            bne   = ($urandom_range(0, 5) == 0);
            cmp   = 1'($urandom_range(0, 1));
            op    = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
            rdy   = (k < 400) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Control-side counterpart of the IF/ID, ID/EX and EX/MEM pipeline registers. Those registers consume stall/flush; this block generates them.
- Detects load-use hazards in ID, taken branches resolved in MEM, and data-memory wait states.
- Drives the stall/flush/PC-redirect strobes from one small FSM and keeps saturating stall/flush event counters.
- Sits beside the datapath in the top-level processor, between decode/execute/memory stage outputs and the pipeline register controls.

Parameters:
NUM_REGISTERS_LOG2, 5, register index width
MEM_OP_BITS, 2, width of mem_op; 0 means no memory access
LOAD_USE_STALLS, 1, bubble cycles inserted per load-use hazard (1..7)
MEM_TIMEOUT, 255, max consecutive MEM_WAIT cycles before mem_timeout_err
CNT_WIDTH, 16, width of perf counters

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
if_id_rs  in  NUM_REGISTERS_LOG2  rs of instruction in ID
if_id_rt  in  NUM_REGISTERS_LOG2  rt of instruction in ID
id_ex_rt  in  NUM_REGISTERS_LOG2  rt (load destination) in EX
id_ex_mem_to_reg  in  1  instruction in EX is a load
ex_mem_beq  in  1  branch-equal in MEM
ex_mem_bne  in  1  branch-not-equal in MEM
ex_mem_compare  in  1  ALU equality result in MEM
ex_mem_mem_op  in  MEM_OP_BITS  memory op in MEM
mem_ready  in  1  data memory completes access this cycle
stall_if  out  1  hold PC and IF/ID
stall_id  out  1  to ID/EX stall (inserts bubble)
flush_id_ex  out  1  to ID/EX flush
flush_ex_mem  out  1  to EX/MEM flush
pc_load_branch  out  1  select branch target for PC
mem_timeout_err  out  1  sticky error
stall_count  out  CNT_WIDTH  saturating count of stall cycles
flush_count  out  CNT_WIDTH  saturating count of branch flushes

Behaviour:
- Reset (reset_n low, asynchronous): state=RUN, bubble counter=0, wait counter=0, mem_timeout_err=0, stall_count=0, flush_count=0. All strobe outputs 0 while reset is held. Reset mid-stall or mid-wait aborts immediately.
- Strobes are combinational from current state plus inputs (zero-latency, same cycle as the hazard). FSM state and counters are registered.
- Definitions:
  - taken = (ex_mem_beq & ex_mem_compare) | (ex_mem_bne & ~ex_mem_compare)
  - load_use = id_ex_mem_to_reg & (id_ex_rt != 0) & (id_ex_rt == if_id_rs | id_ex_rt == if_id_rt)
  - mem_busy = (ex_mem_mem_op != 0) & ~mem_ready
- Priority each cycle: taken > mem_busy > load_use.
- State RUN:
  - taken: pc_load_branch=1, flush_id_ex=1, flush_ex_mem=1 for exactly this cycle; flush_count++; stay RUN.
  - else mem_busy: stall_if=stall_id=1; go MEM_WAIT; wait counter=1.
  - else load_use: stall_if=stall_id=1; stall_count++. If LOAD_USE_STALLS>1, go LOAD_STALL with bubble counter=LOAD_USE_STALLS-1; else stay RUN.
  - else: all strobes 0.
- State LOAD_STALL:
  - stall_if=stall_id=1; stall_count++; counter decrements; return to RUN when it reaches 0 after decrement.
  - A taken branch in this state overrides: flush as in RUN, counter cleared, go RUN.
- State MEM_WAIT:
  - While mem_busy: stall_if=stall_id=1, stall_count++, wait counter++.
  - Wait counter reaching MEM_TIMEOUT sets mem_timeout_err (sticky until reset) and forces RUN.
  - On mem_ready: strobes 0 this cycle, go RUN, wait counter=0.
  - Branch evaluation is suppressed in MEM_WAIT (a branch cannot carry a memory op).
- RUN-entry cycle of a mem_busy stall also increments stall_count.
- Counters saturate at all-ones; no wrap.
- Register index 0 never creates a load-use hazard.

Test Plan:
- Load to r3 in EX (id_ex_mem_to_reg=1, id_ex_rt=3), ID rs=3, LOAD_USE_STALLS=1 -> stall_if=stall_id=1 for one cycle, then 0; stall_count=1.
- Same hazard with id_ex_rt=0 -> no stall, stall_count stays 0.
- ex_mem_bne=1, compare=0, simultaneous load_use -> only pc_load_branch/flush_id_ex/flush_ex_mem=1 for one cycle; no stall; flush_count=1.
- mem_op=1, mem_ready low 4 cycles then high -> stall high 4 cycles, low on ready cycle; stall_count=4.
- MEM_TIMEOUT=8, mem_ready held low -> mem_timeout_err rises after the 8th wait cycle and stays 1; state returns to RUN.
- LOAD_USE_STALLS=3; reset_n pulsed low during the 2nd bubble -> all outputs 0 immediately and counters 0; no further stall after release.
